// File: rtl/uvmt_mem_st_rst_init_pkg.sv
// Shared types and sizing helpers for the reset/init sequencer.
// The address-pattern option is selected in the top with UVMT_MEM_ST_RST_INIT_PATTERN_EN.
package uvmt_mem_st_rst_init_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        STRETCH = 2'd1,
        INIT    = 2'd2,
        DONE    = 2'd3
    } init_state_e;

    localparam int DEFAULT_STRETCH_CYCLES = 8;

    // The stretch counter only has to reach STRETCH_CYCLES-1.
    function automatic int stretch_cnt_width(input int cycles);
        return (cycles < 3) ? 1 : $clog2(cycles);
    endfunction

    localparam int STRETCH_CNT_W = stretch_cnt_width(DEFAULT_STRETCH_CYCLES);

endpackage : uvmt_mem_st_rst_init_pkg

// File: rtl/uvmt_mem_st_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES rising edges.
module uvmt_mem_st_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule : uvmt_mem_st_rst_sync

// File: rtl/uvmt_mem_st_rst_init_seq.sv
// Reset synchronizer/stretcher plus memory init sweep for the memory model under test.
// Define UVMT_MEM_ST_RST_INIT_PATTERN_EN to write INIT_VALUE ^ address instead of INIT_VALUE.
module uvmt_mem_st_rst_init_seq
    import uvmt_mem_st_rst_init_pkg::*;
#(
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_req,
    input  logic                  mem_ready,
    output logic                  sync_reset_n,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [ADDR_WIDTH:0]   init_count
);

    localparam int                    CNT_W        = stretch_cnt_width(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0]      STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = '1;

    logic rst_sync_n;

    uvmt_mem_st_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .rst_sync_n (rst_sync_n)
    );

    init_state_e           state_q,        state_d;
    logic [CNT_W-1:0]      stretch_cnt_q,  stretch_cnt_d;
    logic                  sync_reset_n_q, sync_reset_n_d;
    logic                  mem_we_q,       mem_we_d;
    logic                  init_busy_q,    init_busy_d;
    logic                  init_done_q,    init_done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
    logic [ADDR_WIDTH:0]   init_count_q,   init_count_d;
    logic [DATA_WIDTH-1:0] wdata_pat;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        stretch_cnt_d  = stretch_cnt_q;
        sync_reset_n_d = sync_reset_n_q;
        mem_we_d       = mem_we_q;
        init_busy_d    = init_busy_q;
        init_done_d    = init_done_q;
        mem_addr_d     = mem_addr_q;
        init_count_d   = init_count_q;

        unique case (state_q)
            SYNC: begin
                // The edge that releases the synchronizer is the first stretch edge.
                if (rst_sync_n) begin
                    if (STRETCH_LAST == '0) begin
                        state_d        = INIT;
                        sync_reset_n_d = 1'b1;
                        mem_we_d       = 1'b1;
                        init_busy_d    = 1'b1;
                    end else begin
                        state_d       = STRETCH;
                        stretch_cnt_d = CNT_W'(1);
                    end
                end
            end

            STRETCH: begin
                if (stretch_cnt_q == STRETCH_LAST) begin
                    state_d        = INIT;
                    sync_reset_n_d = 1'b1;
                    mem_we_d       = 1'b1;
                    init_busy_d    = 1'b1;
                    mem_addr_d     = '0;
                    init_count_d   = '0;
                end else begin
                    stretch_cnt_d = stretch_cnt_q + 1'b1;
                end
            end

            INIT: begin
                if (mem_we_q && mem_ready) begin
                    mem_addr_d   = mem_addr_q + 1'b1;
                    init_count_d = init_count_q + 1'b1;
                    if (mem_addr_q == ADDR_LAST) begin
                        state_d     = DONE;
                        mem_we_d    = 1'b0;
                        init_busy_d = 1'b0;
                        init_done_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (init_req) begin
                    state_d      = INIT;
                    mem_we_d     = 1'b1;
                    init_busy_d  = 1'b1;
                    init_done_d  = 1'b0;
                    mem_addr_d   = '0;
                    init_count_d = '0;
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SYNC;
            stretch_cnt_q  <= '0;
            sync_reset_n_q <= 1'b0;
            mem_we_q       <= 1'b0;
            init_busy_q    <= 1'b0;
            init_done_q    <= 1'b0;
            mem_addr_q     <= '0;
            init_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            stretch_cnt_q  <= stretch_cnt_d;
            sync_reset_n_q <= sync_reset_n_d;
            mem_we_q       <= mem_we_d;
            init_busy_q    <= init_busy_d;
            init_done_q    <= init_done_d;
            mem_addr_q     <= mem_addr_d;
            init_count_q   <= init_count_d;
        end
    end

`ifdef UVMT_MEM_ST_RST_INIT_PATTERN_EN
    assign wdata_pat = INIT_VALUE ^ DATA_WIDTH'(mem_addr_q);
`else
    assign wdata_pat = INIT_VALUE;
`endif

    // Data is only driven while a write is valid, so every output reads 0 in reset.
    assign mem_wdata    = mem_we_q ? wdata_pat : '0;
    assign sync_reset_n = sync_reset_n_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign init_busy    = init_busy_q;
    assign init_done    = init_done_q;
    assign init_count   = init_count_q;

endmodule : uvmt_mem_st_rst_init_seq

// File: tb/tb_uvmt_mem_st_rst_init_seq.sv
// Scoreboard bench for uvmt_mem_st_rst_init_seq at ADDR_WIDTH=4, SYNC_STAGES=2, STRETCH_CYCLES=8.
module tb_uvmt_mem_st_rst_init_seq;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] IVAL  = 32'hA5A5_0000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_req;
    logic          mem_ready;
    logic          sync_reset_n;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          init_busy;
    logic          init_done;
    logic [AW:0]   init_count;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    uvmt_mem_st_rst_init_seq #(
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (8),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .INIT_VALUE     (IVAL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .init_req     (init_req),
        .mem_ready    (mem_ready),
        .sync_reset_n (sync_reset_n),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .init_count   (init_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int addr);
`ifdef UVMT_MEM_ST_RST_INIT_PATTERN_EN
        return IVAL ^ DW'(addr);
`else
        return IVAL;
`endif
    endfunction

    task automatic push_sweep();
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            exp_q.push_back('{addr: AW'(i), data: exp_data(i)});
        end
    endtask

    // Accepts happen at the next rising edge; sample at the falling edge.
    always @(negedge clk) begin
        if (reset_n && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_addr", 64'(mem_addr), 64'(e.addr));
                check("sb_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    // Called at posedge+1 with reset_n low; counts edges until the first write.
    task automatic release_and_measure();
        int n;
        n = 0;
        reset_n = 1'b1;
        while (!mem_we && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            init_req = (n == 5);
            if (n == 9) check("sync_rst_low_edge9", 64'(sync_reset_n), 0);
        end
        init_req = 1'b0;
        check("first_write_edge", 64'(n), 10);
        check("sync_rst_at_init", 64'(sync_reset_n), 1);
        check("first_addr", 64'(mem_addr), 0);
        check("busy_at_init", 64'(init_busy), 1);
    endtask

    task automatic wait_addr(input int a);
        int n;
        n = 0;
        while (mem_addr != AW'(a) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_addr", 64'(mem_addr), 64'(a));
    endtask

    task automatic finish_sweep();
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done", 64'(init_done), 1);
        check("done_count", 64'(init_count), 64'(WORDS));
        check("done_addr_wrap", 64'(mem_addr), 0);
        check("done_we", 64'(mem_we), 0);
        check("done_busy", 64'(init_busy), 0);
        check("done_sync_rst", 64'(sync_reset_n), 1);
        check("sb_drained", 64'(exp_q.size()), 0);
    endtask

    task automatic start_resweep();
        push_sweep();
        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        check("resweep_done_clr", 64'(init_done), 0);
        check("resweep_count_clr", 64'(init_count), 0);
        check("resweep_addr", 64'(mem_addr), 0);
        check("resweep_we", 64'(mem_we), 1);
        check("resweep_sync_rst", 64'(sync_reset_n), 1);
    endtask

    initial begin
        logic [DW-1:0] held;
        int            n;

        reset_n   = 1'b0;
        init_req  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_rst", 64'(sync_reset_n), 0);
        check("rst_we", 64'(mem_we), 0);
        check("rst_busy", 64'(init_busy), 0);
        check("rst_done", 64'(init_done), 0);
        check("rst_count", 64'(init_count), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_wdata", 64'(mem_wdata), 0);

        // Power-on sweep with the memory always ready.
        push_sweep();
        release_and_measure();
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sweep_cycles", 64'(n), 64'(WORDS));
        finish_sweep();

        // Re-sweep with a 3-cycle stall at addr 5 and an ignored request at addr 7.
        start_resweep();
        wait_addr(5);
        mem_ready = 1'b0;
        held = mem_wdata;
        check("stall_count", 64'(init_count), 5);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_addr", 64'(mem_addr), 5);
            check("stall_data", 64'(mem_wdata), 64'(held));
        end
        mem_ready = 1'b1;
        wait_addr(7);
        init_req = 1'b1;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        finish_sweep();
        repeat (3) @(posedge clk);
        #1;
        check("stay_done", 64'(init_done), 1);
        check("stay_idle_we", 64'(mem_we), 0);
        check("stay_count", 64'(init_count), 64'(WORDS));

        // Reset mid-sweep at addr 9, then full restart.
        start_resweep();
        wait_addr(9);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_sync_rst", 64'(sync_reset_n), 0);
        check("midrst_we", 64'(mem_we), 0);
        check("midrst_busy", 64'(init_busy), 0);
        check("midrst_done", 64'(init_done), 0);
        check("midrst_count", 64'(init_count), 0);
        repeat (2) @(posedge clk);
        #1;
        push_sweep();
        release_and_measure();
        finish_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uvmt_mem_st_rst_init_seq
